// File: rtl/debounce_pkg.sv
// Shared types and helpers for the input debouncer and its synchronizer.
package debounce_pkg;

   // Two-state confirmation FSM: idle on a settled level, or timing a candidate.
   typedef enum logic {
      STABLE  = 1'b0,
      CONFIRM = 1'b1
   } debounce_state_t;

   // Confirmation counter width: max(1, clog2(n)) so a single-tick window still
   // gets a real one-bit register instead of a zero-width vector.
   function automatic int cnt_width(input int n);
      if (n <= 1) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit. The chain depth is a
// parameter (2 or more) so slower or noisier domains can add stages. Reset is
// asynchronous active-low and loads every stage with RESET_LEVEL so the output
// matches the debounced level it feeds while reset is asserted.
module bit_synchronizer #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   output logic a_s
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [SYNC_STAGES-1:0] sync_next;

   // Stage 0 captures the raw input; every later stage copies its predecessor.
   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign sync_next[gi] = a;
         end else begin : g_chain
            assign sync_next[gi] = sync_reg[gi-1];
         end
      end
   endgenerate

   // Shift the chain every clock; reset forces all stages to the reset level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_reg <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_reg <= sync_next;
      end
   end

   assign a_s = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debouncer for a raw, asynchronous 1-bit input. The input is synchronized,
// then any difference from the current output level starts a confirmation
// window. The new level is accepted only if it persists for STABLE_CYCLES
// qualifying ticks; a reversion during the window abandons the candidate and
// raises a one-cycle glitch flag. The output q is meant to drive edge/pulse
// detectors directly, so it only ever changes cleanly and synchronously.
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int   SYNC_STAGES   = 2,
   parameter int   STABLE_CYCLES = 4,
   parameter logic RESET_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic tick,
   output logic q,
   output logic glitch,
   output logic busy
);

   localparam int              CNT_W    = cnt_width(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic            a_s;
   debounce_state_t state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic            q_reg, q_next;
   logic            glitch_reg, glitch_next;

   // Metastability guard: only the last synchronizer stage is observed below.
   bit_synchronizer #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_LEVEL (RESET_LEVEL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .a_s (a_s)
   );

   // State, counter and output registers; reset drops any pending candidate
   // without flagging it as a glitch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= STABLE;
         cnt_reg    <= '0;
         q_reg      <= RESET_LEVEL;
         glitch_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         q_reg      <= q_next;
         glitch_reg <= glitch_next;
      end
   end

   // Next-state logic. Detection and abandonment ignore tick so a candidate is
   // noticed (and dropped) at full clock rate; only the counting is throttled.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      q_next      = q_reg;
      glitch_next = 1'b0;

      unique case (state_reg)
         STABLE: begin
            if (a_s != q_reg) begin
               state_next = CONFIRM;
               cnt_next   = '0;
            end
         end

         CONFIRM: begin
            if (a_s == q_reg) begin
               // Input fell back before the window completed: bounce.
               state_next  = STABLE;
               cnt_next    = '0;
               glitch_next = 1'b1;
            end else if (tick && (cnt_reg == CNT_LAST)) begin
               // Window complete: accept exactly one level change.
               state_next = STABLE;
               cnt_next   = '0;
               q_next     = ~q_reg;
            end else if (tick) begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         default: begin
            state_next = STABLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign q      = q_reg;
   assign glitch = glitch_reg;
   assign busy   = (state_reg == CONFIRM);

endmodule

// File: tb/tb_input_debouncer.sv
// Directed testbench for input_debouncer: a default-parameter instance plus a
// variant instance (STABLE_CYCLES=1, RESET_LEVEL=1, SYNC_STAGES=3). Edges are
// numbered from the first rising edge after the input is changed.
module tb_input_debouncer;

   logic clk;
   logic rst;
   logic a;
   logic tick;
   logic q, glitch, busy;

   logic a_v;
   logic q_v, glitch_v, busy_v;

   int n_checks;
   int n_fail;

   input_debouncer #(
      .SYNC_STAGES   (2),
      .STABLE_CYCLES (4),
      .RESET_LEVEL   (1'b0)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .tick   (tick),
      .q      (q),
      .glitch (glitch),
      .busy   (busy)
   );

   input_debouncer #(
      .SYNC_STAGES   (3),
      .STABLE_CYCLES (1),
      .RESET_LEVEL   (1'b1)
   ) dut_v (
      .clk    (clk),
      .rst    (rst),
      .a      (a_v),
      .tick   (1'b1),
      .q      (q_v),
      .glitch (glitch_v),
      .busy   (busy_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock with the given tick value; outputs are sampled 1 time unit later.
   task automatic cycle(input logic t);
      tick = t;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic prev_qv;
      logic pulse;
      n_checks = 0;
      n_fail   = 0;
      rst  = 1'b0;
      a    = 1'b1;
      a_v  = 1'b1;
      tick = 1'b1;

      // Reset with input high: outputs held at reset values.
      repeat (3) cycle(1'b1);
      check_value("rst_q", q, 1'b0);
      check_value("rst_busy", busy, 1'b0);
      check_value("rst_glitch", glitch, 1'b0);
      check_value("rst_v_q", q_v, 1'b1);

      // Release with a=1: busy after edge 2, q rises and busy drops after edge 6.
      rst = 1'b1;
      for (int e = 0; e <= 7; e++) begin
         cycle(1'b1);
         check_value("t1_busy", busy, (e >= 2 && e <= 5));
         check_value("t1_q", q, (e >= 6));
         check_value("t1_glitch", glitch, 1'b0);
         $display("t1 edge %0d q=%b busy=%b glitch=%b", e, q, busy, glitch);
      end

      // Falling edge from q=1.
      a = 1'b0;
      for (int e = 0; e <= 7; e++) begin
         cycle(1'b1);
         check_value("t3_busy", busy, (e >= 2 && e <= 5));
         check_value("t3_q", q, (e < 6));
         $display("t3 edge %0d q=%b busy=%b", e, q, busy);
      end

      // Bounce: a=1 for edges 0..2, then back to 0.
      for (int e = 0; e <= 8; e++) begin
         a = (e <= 2);
         cycle(1'b1);
         check_value("t2_busy", busy, (e >= 2 && e <= 4));
         check_value("t2_glitch", glitch, (e == 5));
         check_value("t2_q", q, 1'b0);
         $display("t2 edge %0d q=%b busy=%b glitch=%b", e, q, busy, glitch);
      end

      // Throttled tick (edges 3,7,11,15,...): CONFIRM at edge 2, toggle at 15.
      a = 1'b1;
      for (int e = 0; e <= 17; e++) begin
         cycle((e % 4) == 3);
         check_value("t4_busy", busy, (e >= 2 && e <= 14));
         check_value("t4_q", q, (e >= 15));
         check_value("t4_glitch", glitch, 1'b0);
         $display("t4 edge %0d tick=%b q=%b busy=%b", e, tick, q, busy);
      end

      // Throttled tick, bounce: a drops before edge 0, returns before edge 4;
      // glitch after edge 6, which is not a tick edge.
      for (int e = 0; e <= 9; e++) begin
         a = (e >= 4);
         cycle((e % 4) == 3);
         check_value("t4g_busy", busy, (e >= 2 && e <= 5));
         check_value("t4g_glitch", glitch, (e == 6));
         check_value("t4g_q", q, 1'b1);
         $display("t4g edge %0d tick=%b q=%b busy=%b glitch=%b", e, tick, q, busy, glitch);
      end

      // Reset mid-confirm: takes effect without a clock edge, no glitch.
      a = 1'b0;
      for (int e = 0; e <= 2; e++) cycle(1'b1);
      check_value("t5_busy_pre", busy, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check_value("t5_q", q, 1'b0);
      check_value("t5_busy", busy, 1'b0);
      check_value("t5_glitch", glitch, 1'b0);
      $display("t5 async reset q=%b busy=%b glitch=%b", q, busy, glitch);
      for (int e = 0; e <= 1; e++) begin
         cycle(1'b1);
         check_value("t5_glitch_hold", glitch, 1'b0);
         check_value("t5_busy_hold", busy, 1'b0);
      end
      rst = 1'b1;
      for (int e = 0; e <= 3; e++) begin
         cycle(1'b1);
         check_value("t5_after_busy", busy, 1'b0);
         check_value("t5_after_q", q, 1'b0);
      end

      // Variant: q_v starts at 1; dropping a_v gives q_v=0 after edge 4.
      check_value("v_reset_q", q_v, 1'b1);
      prev_qv = q_v;
      a_v = 1'b0;
      for (int e = 0; e <= 5; e++) begin
         cycle(1'b1);
         pulse   = q_v & ~prev_qv;
         prev_qv = q_v;
         check_value("v_fall_q", q_v, (e < 4));
         check_value("v_fall_busy", busy_v, (e == 3));
         check_value("v_fall_pulse", pulse, 1'b0);
         $display("v fall edge %0d q=%b busy=%b", e, q_v, busy_v);
      end

      // Variant bounce: one-cycle blip is rejected with a glitch after edge 4.
      for (int e = 0; e <= 6; e++) begin
         a_v = (e == 0);
         cycle(1'b1);
         pulse   = q_v & ~prev_qv;
         prev_qv = q_v;
         check_value("v_bounce_q", q_v, 1'b0);
         check_value("v_bounce_busy", busy_v, (e == 3));
         check_value("v_bounce_glitch", glitch_v, (e == 4));
         check_value("v_bounce_pulse", pulse, 1'b0);
         $display("v bounce edge %0d q=%b busy=%b glitch=%b", e, q_v, busy_v, glitch_v);
      end

      // Variant accepted rise: exactly one posedge pulse, after edge 4.
      a_v = 1'b1;
      for (int e = 0; e <= 7; e++) begin
         cycle(1'b1);
         pulse   = q_v & ~prev_qv;
         prev_qv = q_v;
         check_value("v_rise_q", q_v, (e >= 4));
         check_value("v_rise_pulse", pulse, (e == 4));
         $display("v rise edge %0d q=%b pulse=%b", e, q_v, pulse);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
